// File: rtl/b_registered_mac_multi_ch_if.sv
// Bus for b_registered_mac_multi_ch: input beat handshake, operand and
// control fields, output handshake and results.
// The master side drives beats and out_ready; the slave side is the MAC block.
interface b_registered_mac_multi_ch_if #(
  parameter int NUM_CH = 4,
  parameter int A_W    = 20,
  parameter int B_W    = 18,
  parameter int ACC_W  = 38
);
  localparam int ID_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic             in_valid;
  logic             in_ready;
  logic [ID_W-1:0]  id;
  logic [A_W-1:0]   a;
  logic [B_W-1:0]   b;
  logic             unsigned_a;
  logic             unsigned_b;
  logic             load_acc;
  logic             subtract;
  logic             out_valid;
  logic             out_ready;
  logic [ID_W-1:0]  out_id;
  logic [ACC_W-1:0] z_out;
  logic [B_W-1:0]   dly_b;

  modport master (
    output in_valid, id, a, b, unsigned_a, unsigned_b, load_acc, subtract, out_ready,
    input  in_ready, out_valid, out_id, z_out, dly_b
  );

  modport slave (
    input  in_valid, id, a, b, unsigned_a, unsigned_b, load_acc, subtract, out_ready,
    output in_ready, out_valid, out_id, z_out, dly_b
  );
endinterface

// File: rtl/b_registered_mac_multi_ch.sv
// Multi-channel registered multiply-accumulate pipeline.
// IN_STAGES input registers -> product register -> accumulate/output register,
// with one accumulator per channel and valid/ready flow control.
// Optional feature: define B_REG_MAC_SATURATE_EN to clamp accumulation results
// instead of wrapping modulo 2^ACC_W.
module b_registered_mac_multi_ch #(
  parameter int NUM_CH    = 4,
  parameter int A_W       = 20,
  parameter int B_W       = 18,
  parameter int ACC_W     = 38,
  parameter int IN_STAGES = 1
) (
  input logic                      i_clock0,
  input logic                      i_reset,
  b_registered_mac_multi_ch_if.slave io_bus
);
  localparam int ID_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int P_W  = A_W + B_W;

  typedef struct packed {
    logic [ID_W-1:0] id;
    logic [A_W-1:0]  a;
    logic [B_W-1:0]  b;
    logic            ua;
    logic            ub;
    logic            load;
    logic            sub;
  } beat_t;

  // Flow control: a held output freezes the whole pipe.
  logic w_stall;
  logic w_accept;
  logic r_out_valid;

  assign w_stall         = r_out_valid & ~io_bus.out_ready;
  assign io_bus.in_ready = ~w_stall;
  assign w_accept        = io_bus.in_valid & ~w_stall;

  beat_t w_in_beat;
  assign w_in_beat = '{id: io_bus.id, a: io_bus.a, b: io_bus.b,
                       ua: io_bus.unsigned_a, ub: io_bus.unsigned_b,
                       load: io_bus.load_acc, sub: io_bus.subtract};

  // ---------------- input register stages ----------------
  logic [IN_STAGES-1:0] r_stg_v;
  beat_t                r_stg [IN_STAGES];

  // Input stage valids: shift on every non-stalled cycle, bubbles included.
  always_ff @(posedge i_clock0) begin
    if (i_reset) begin
      r_stg_v <= '0;
    end else if (!w_stall) begin
      r_stg_v[0] <= w_accept;
      for (int s = 1; s < IN_STAGES; s++) r_stg_v[s] <= r_stg_v[s-1];
    end
  end

  // Input stage payload.
  // NOTE: payload registers are qualified by their valid bits, so they carry no reset.
  always_ff @(posedge i_clock0) begin
    if (!w_stall) begin
      r_stg[0] <= w_in_beat;
      for (int s = 1; s < IN_STAGES; s++) r_stg[s] <= r_stg[s-1];
    end
  end

  // What is about to enter the last input stage.
  logic           w_last_v_in;
  logic [B_W-1:0] w_last_b_in;

  generate
    if (IN_STAGES == 1) begin : g_one_stage
      assign w_last_v_in = w_accept;
      assign w_last_b_in = io_bus.b;
    end else begin : g_multi_stage
      assign w_last_v_in = r_stg_v[IN_STAGES-2];
      assign w_last_b_in = r_stg[IN_STAGES-2].b;
    end
  endgenerate

  logic [B_W-1:0] r_dly_b;

  // dly_b tracks b of the last input stage, but only for real beats.
  always_ff @(posedge i_clock0) begin
    if (i_reset) begin
      r_dly_b <= '0;
    end else if (!w_stall && w_last_v_in) begin
      r_dly_b <= w_last_b_in;
    end
  end

  // ---------------- multiply ----------------
  beat_t                 w_last;
  logic signed [A_W:0]   w_a_ext;
  logic signed [B_W:0]   w_b_ext;
  logic signed [P_W-1:0] w_a_p;
  logic signed [P_W-1:0] w_b_p;
  logic signed [P_W-1:0] w_prod;

  // An extra top bit holds the sign (or a zero) so one signed multiplier covers all modes.
  assign w_last  = r_stg[IN_STAGES-1];
  assign w_a_ext = {~w_last.ua & w_last.a[A_W-1], w_last.a};
  assign w_b_ext = {~w_last.ub & w_last.b[B_W-1], w_last.b};
  assign w_a_p   = P_W'(w_a_ext);
  assign w_b_p   = P_W'(w_b_ext);
  assign w_prod  = w_a_p * w_b_p;

  logic            r_p_v;
  logic [P_W-1:0]  r_p;
  logic            r_p_signed;
  logic [ID_W-1:0] r_p_id;
  logic            r_p_load;
  logic            r_p_sub;

  // Product stage valid.
  always_ff @(posedge i_clock0) begin
    if (i_reset) begin
      r_p_v <= 1'b0;
    end else if (!w_stall) begin
      r_p_v <= r_stg_v[IN_STAGES-1];
    end
  end

  // Product stage payload; the beat is signed when either operand is signed.
  always_ff @(posedge i_clock0) begin
    if (!w_stall) begin
      r_p        <= w_prod;
      r_p_signed <= ~(w_last.ua & w_last.ub);
      r_p_id     <= w_last.id;
      r_p_load   <= w_last.load;
      r_p_sub    <= w_last.sub;
    end
  end

  // ---------------- accumulate ----------------
  logic [ACC_W-1:0] r_acc [NUM_CH];
  logic [ACC_W-1:0] r_z;
  logic [ID_W-1:0]  r_out_id;
  logic [ACC_W-1:0] w_new;

`ifdef B_REG_MAC_SATURATE_EN
  localparam int E_W = ACC_W + 2;
  localparam logic signed [E_W-1:0] S_MAX = {3'b000, {(ACC_W-1){1'b1}}};
  localparam logic signed [E_W-1:0] S_MIN = {3'b111, {(ACC_W-1){1'b0}}};
  localparam logic signed [E_W-1:0] U_MAX = {2'b00, {ACC_W{1'b1}}};

  logic signed [E_W-1:0] w_base_e;
  logic signed [E_W-1:0] w_p_e;
  logic signed [E_W-1:0] w_sum_e;

  // Widened accumulate, then clamp to the range of the beat's signedness.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    w_base_e = '0;
    w_p_e    = '0;
    if (r_p_signed) begin
      w_p_e = E_W'($signed(r_p));
      if (!r_p_load) w_base_e = E_W'($signed(r_acc[r_p_id]));
    end else begin
      w_p_e = E_W'(r_p);
      if (!r_p_load) w_base_e = E_W'(r_acc[r_p_id]);
    end
    w_sum_e = r_p_sub ? (w_base_e - w_p_e) : (w_base_e + w_p_e);
    w_new   = w_sum_e[ACC_W-1:0];
    if (r_p_signed) begin
      if (w_sum_e > S_MAX)      w_new = S_MAX[ACC_W-1:0];
      else if (w_sum_e < S_MIN) w_new = S_MIN[ACC_W-1:0];
    end else begin
      if (w_sum_e < 0)          w_new = '0;
      else if (w_sum_e > U_MAX) w_new = U_MAX[ACC_W-1:0];
    end
  end
`else
  logic [ACC_W-1:0] w_p_ext;
  logic [ACC_W-1:0] w_base;

  // Plain modulo-2^ACC_W accumulate.
  always_comb begin
    w_p_ext = r_p_signed ? ACC_W'($signed(r_p)) : ACC_W'(r_p);
    w_base  = r_p_load ? '0 : r_acc[r_p_id];
    w_new   = r_p_sub ? (w_base - w_p_ext) : (w_base + w_p_ext);
  end
`endif

  // Accumulator write and output register share one edge, so a same-channel
  // beat on the next cycle already sees the updated value.
  // NOTE: the accumulator array is architectural state and must be cleared on reset.
  always_ff @(posedge i_clock0) begin
    if (i_reset) begin
      r_out_valid <= 1'b0;
      r_z         <= '0;
      r_out_id    <= '0;
      for (int c = 0; c < NUM_CH; c++) r_acc[c] <= '0;
    end else if (!w_stall) begin
      r_out_valid <= r_p_v;
      if (r_p_v) begin
        r_acc[r_p_id] <= w_new;
        r_z           <= w_new;
        r_out_id      <= r_p_id;
      end
    end
  end

  assign io_bus.out_valid = r_out_valid;
  assign io_bus.out_id    = r_out_id;
  assign io_bus.z_out     = r_z;
  assign io_bus.dly_b     = r_dly_b;
endmodule

// File: tb/tb_b_registered_mac_multi_ch.sv
// Bench for b_registered_mac_multi_ch: directed beats with hand-computed
// accumulator values go into a scoreboard queue; a negedge monitor checks
// every accepted output and the hold/in_ready behaviour during stalls.
module tb_b_registered_mac_multi_ch;
  localparam int NUM_CH = 4;
  localparam int A_W    = 20;
  localparam int B_W    = 18;
  localparam int ACC_W  = 38;

  typedef struct {
    logic [1:0]       id;
    logic [A_W-1:0]   a;
    logic [B_W-1:0]   b;
    logic             ua;
    logic             ub;
    logic             ld;
    logic             sub;
    logic [ACC_W-1:0] exp;
  } vec_t;

  typedef struct packed {
    logic [1:0]       id;
    logic [ACC_W-1:0] z;
  } exp_t;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;
  exp_t exp_q[$];

  logic             prev_stall;
  logic [ACC_W-1:0] prev_z;
  logic [1:0]       prev_id;

  b_registered_mac_multi_ch_if #(.NUM_CH(NUM_CH), .A_W(A_W), .B_W(B_W), .ACC_W(ACC_W)) bus ();

  b_registered_mac_multi_ch #(
    .NUM_CH(NUM_CH), .A_W(A_W), .B_W(B_W), .ACC_W(ACC_W), .IN_STAGES(1)
  ) dut (
    .i_clock0 (clk),
    .i_reset  (rst),
    .io_bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input int id, input int a, input int b, input bit ua,
                              input bit ub, input bit ld, input bit sub,
                              input logic [ACC_W-1:0] exp);
    vec_t v;
    v.id = 2'(id); v.a = A_W'(a); v.b = B_W'(b);
    v.ua = ua; v.ub = ub; v.ld = ld; v.sub = sub; v.exp = exp;
    return v;
  endfunction

  // Present one beat and return just after the edge that accepts it.
  task automatic send(input vec_t v);
    int  waited;
    bit  done;
    waited         = 0;
    done           = 0;
    bus.id         = v.id;
    bus.a          = v.a;
    bus.b          = v.b;
    bus.unsigned_a = v.ua;
    bus.unsigned_b = v.ub;
    bus.load_acc   = v.ld;
    bus.subtract   = v.sub;
    bus.in_valid   = 1'b1;
    while (!done) begin
      @(negedge clk);
      if (bus.in_ready) begin
        exp_q.push_back('{id: v.id, z: v.exp});
        done = 1;
      end
      @(posedge clk); #1;
      if (!done) begin
        waited++;
        if (waited > 50) begin
          check("in_ready_timeout", 64'(0), 64'(1));
          done = 1;
        end
      end
    end
    bus.in_valid = 1'b0;
  endtask

  // Wait (bounded) until every expected output has been seen.
  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || bus.out_valid) && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check(name, 64'(exp_q.size()), 64'(0));
  endtask

  // Scoreboard monitor: compare on each output handshake, check stall holds.
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("hold_valid", 64'(bus.out_valid), 64'(1));
        check("hold_z", 64'(bus.z_out), 64'(prev_z));
        check("hold_id", 64'(bus.out_id), 64'(prev_id));
      end
      if (bus.out_valid && !bus.out_ready)
        check("in_ready_stall", 64'(bus.in_ready), 64'(0));
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_output", 64'(bus.z_out), 64'hDEAD_0000_0000_0000);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("z_out", 64'(bus.z_out), 64'(e.z));
          check("out_id", 64'(bus.out_id), 64'(e.id));
        end
      end
      prev_stall = bus.out_valid & ~bus.out_ready;
      prev_z     = bus.z_out;
      prev_id    = bus.out_id;
    end
  end

  vec_t t2 [4];
  vec_t t4 [6];
  vec_t t5 [3];

  initial begin
    n_tests        = 0;
    n_fail         = 0;
    prev_stall     = 1'b0;
    prev_z         = '0;
    prev_id        = '0;
    rst            = 1'b1;
    bus.in_valid   = 1'b0;
    bus.out_ready  = 1'b1;
    bus.id         = '0;
    bus.a          = '0;
    bus.b          = '0;
    bus.unsigned_a = 1'b0;
    bus.unsigned_b = 1'b0;
    bus.load_acc   = 1'b0;
    bus.subtract   = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 64'(bus.out_valid), 64'(0));
    check("rst_z_out", 64'(bus.z_out), 64'(0));
    check("rst_out_id", 64'(bus.out_id), 64'(0));
    check("rst_dly_b", 64'(bus.dly_b), 64'(0));
    rst = 1'b0;
    check("rst_in_ready", 64'(bus.in_ready), 64'(1));

    // 1: single beat, latency and dly_b
    send(mk(2, 3, 5, 1, 1, 1, 0, 38'd15));
    check("t1_dly_b", 64'(bus.dly_b), 64'(5));
    check("t1_valid_c1", 64'(bus.out_valid), 64'(0));
    @(posedge clk); #1;
    check("t1_valid_c2", 64'(bus.out_valid), 64'(0));
    @(posedge clk); #1;
    check("t1_valid_c3", 64'(bus.out_valid), 64'(1));
    wait_drain("t1_drain");

    // 2: interleaved channels, back to back
    t2[0] = mk(0, 2, 2, 1, 1, 1, 0, 38'd4);
    t2[1] = mk(1, 7, 1, 1, 1, 1, 0, 38'd7);
    t2[2] = mk(0, 1, 4, 1, 1, 0, 0, 38'd8);
    t2[3] = mk(0, 1, 1, 1, 1, 0, 1, 38'd7);
    for (int i = 0; i < 4; i++) send(t2[i]);
    check("t2_dly_b", 64'(bus.dly_b), 64'(1));
    wait_drain("t2_drain");

    // 3: signed operand a = -1
    send(mk(3, 20'hFFFFF, 3, 0, 1, 1, 0, 38'h3F_FFFF_FFFD));
    wait_drain("t3_drain");

    // 4: backpressure on the first output of a 6-beat stream
    t4[0] = mk(2, 1, 1, 1, 1, 1, 0, 38'd1);
    t4[1] = mk(3, 5, 5, 1, 1, 1, 0, 38'd25);
    t4[2] = mk(2, 2, 1, 1, 1, 0, 0, 38'd3);
    t4[3] = mk(3, 1, 1, 1, 1, 0, 0, 38'd26);
    t4[4] = mk(2, 3, 1, 1, 1, 0, 0, 38'd6);
    t4[5] = mk(3, 2, 3, 1, 1, 0, 1, 38'd20);
    fork
      begin
        for (int i = 0; i < 6; i++) send(t4[i]);
      end
      begin
        int n;
        n = 0;
        while (!bus.out_valid && n < 50) begin
          @(posedge clk); #1;
          n++;
        end
        check("t4_first_valid", 64'(bus.out_valid), 64'(1));
        bus.out_ready = 1'b0;
        repeat (3) begin
          @(posedge clk); #1;
          check("t4_in_ready_low", 64'(bus.in_ready), 64'(0));
        end
        bus.out_ready = 1'b1;
      end
    join
    wait_drain("t4_drain");

    // 5: build acc = 2^37-1 on channel 0, then add 1
    t5[0] = mk(0, 1048575, 131071, 1, 0, 1, 0, 38'h1F_FFEE_0001);
    t5[1] = mk(0, 589823, 2, 1, 0, 0, 0, 38'h1F_FFFF_FFFF);
`ifdef B_REG_MAC_SATURATE_EN
    t5[2] = mk(0, 1, 1, 0, 0, 0, 0, 38'h1F_FFFF_FFFF);
`else
    t5[2] = mk(0, 1, 1, 0, 0, 0, 0, 38'h20_0000_0000);
`endif
    for (int i = 0; i < 3; i++) send(t5[i]);
    wait_drain("t5_drain");

    // 6: reset with two beats in flight
    send(mk(1, 3, 3, 1, 1, 1, 0, 38'd9));
    send(mk(2, 4, 4, 1, 1, 1, 0, 38'd16));
    rst = 1'b1;
    exp_q.delete();
    @(posedge clk); #1;
    check("t6_valid_after_rst", 64'(bus.out_valid), 64'(0));
    check("t6_z_after_rst", 64'(bus.z_out), 64'(0));
    rst = 1'b0;
    check("t6_in_ready", 64'(bus.in_ready), 64'(1));
    send(mk(1, 1, 1, 1, 1, 0, 0, 38'd1));
    send(mk(2, 1, 1, 1, 1, 0, 0, 38'd1));
    wait_drain("t6_drain");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
